// File: rtl/frag_buffer_pkg.sv
// Shared widths and types for the TL TX fragmentation buffer.
// The arbiter packs up to WR_LOCS DWs per write and the reader drains up to RD_LOCS per pop.
package frag_buffer_pkg;

    localparam int unsigned LOC_WIDTH       = 32;
    localparam int unsigned WR_LOCS         = 8;
    localparam int unsigned RD_LOCS         = 4;
    localparam int unsigned DEPTH           = 32;
    localparam int unsigned WR_DATA_WIDTH   = WR_LOCS * LOC_WIDTH;
    localparam int unsigned RD_DATA_WIDTH   = RD_LOCS * LOC_WIDTH;
    localparam int unsigned NO_LOC_WR_WIDTH = $clog2(WR_LOCS + 1);
    localparam int unsigned NO_LOC_RD_WIDTH = $clog2(RD_LOCS + 1);
    localparam int unsigned PTR_WIDTH       = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH       = $clog2(DEPTH + 1);

    typedef logic [LOC_WIDTH-1:0] loc_t;
    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/frag_buffer_if.sv
// Arbiter-to-buffer write interface; the buffer sits on the slave side.
interface frag_buffer_if;
    import frag_buffer_pkg::*;

    logic                       wr_en;
    logic [WR_DATA_WIDTH-1:0]   data_in;
    logic [NO_LOC_WR_WIDTH-1:0] no_loc_wr;
    logic                       empty;

    modport master (output wr_en, output data_in, output no_loc_wr, input empty);
    modport slave  (input wr_en, input data_in, input no_loc_wr, output empty);

endinterface

// File: rtl/frag_buffer_ptr_ctrl.sv
// Pointer, occupancy and overflow tracking for frag_buffer.
// A write is all-or-nothing and only sees space that is free before any same-cycle read.
module frag_buffer_ptr_ctrl
    import frag_buffer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [NO_LOC_WR_WIDTH-1:0] no_loc_wr,
    input  logic                       rd_en,
    output logic                       wr_accept_c,
    output ptr_t                       wr_ptr,
    output ptr_t                       rd_ptr,
    output cnt_t                       count,
    output cnt_t                       free_locs_c,
    output logic [NO_LOC_RD_WIDTH-1:0] rd_no_loc_c,
    output logic                       overflow_err
);

    logic wr_req;
    logic wr_drop;
    logic rd_take;
    cnt_t wr_locs;
    cnt_t rd_locs;
    cnt_t count_next;

    // Accept/drop decision and next occupancy
    always_comb begin
        free_locs_c = cnt_t'(DEPTH) - count;
        rd_no_loc_c = (count >= cnt_t'(RD_LOCS)) ? NO_LOC_RD_WIDTH'(RD_LOCS)
                                                 : NO_LOC_RD_WIDTH'(count);
        wr_req      = wr_en && (no_loc_wr != '0);
        wr_accept_c = wr_req
                   && (no_loc_wr <= NO_LOC_WR_WIDTH'(WR_LOCS))
                   && (cnt_t'(no_loc_wr) <= free_locs_c);
        wr_drop     = wr_req && !wr_accept_c;
        rd_take     = rd_en && (count != '0);
        wr_locs     = wr_accept_c ? cnt_t'(no_loc_wr) : '0;
        rd_locs     = rd_take ? cnt_t'(rd_no_loc_c) : '0;
        count_next  = count + wr_locs - rd_locs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (wr_accept_c) begin
                wr_ptr <= wr_ptr + ptr_t'(no_loc_wr);
            end
            if (rd_take) begin
                rd_ptr <= rd_ptr + ptr_t'(rd_no_loc_c);
            end
            count <= count_next;
            if (wr_drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/frag_buffer.sv
// Multi-location FIFO between the TX arbiter and the fragmentation reader.
// Variable-span write port into a circular array; reads present the oldest RD_LOCS slots.
module frag_buffer
    import frag_buffer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    frag_buffer_if.slave               wr_if,
    input  logic                       rd_en,
    output logic [RD_DATA_WIDTH-1:0]   rd_data,
    output logic [NO_LOC_RD_WIDTH-1:0] rd_no_loc,
    output logic [CNT_WIDTH-1:0]       free_locs,
    output logic                       overflow_err
);

    loc_t mem [DEPTH];
    logic wr_accept_c;
    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t count;
    cnt_t free_locs_c;
    logic [NO_LOC_RD_WIDTH-1:0] rd_no_loc_c;

    frag_buffer_ptr_ctrl u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_if.wr_en),
        .no_loc_wr    (wr_if.no_loc_wr),
        .rd_en        (rd_en),
        .wr_accept_c  (wr_accept_c),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .free_locs_c  (free_locs_c),
        .rd_no_loc_c  (rd_no_loc_c),
        .overflow_err (overflow_err)
    );

    // Storage is not reset; pointer wrap handles writes straddling the end
    always_ff @(posedge clk) begin
        if (!rst && wr_accept_c) begin
            for (int i = 0; i < int'(WR_LOCS); i++) begin
                if (NO_LOC_WR_WIDTH'(i) < wr_if.no_loc_wr) begin
                    mem[wr_ptr + ptr_t'(i)] <= wr_if.data_in[i*LOC_WIDTH +: LOC_WIDTH];
                end
            end
        end
    end

    // Read window: unused slots forced to zero
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < int'(RD_LOCS); j++) begin
            if (NO_LOC_RD_WIDTH'(j) < rd_no_loc_c) begin
                rd_data[j*LOC_WIDTH +: LOC_WIDTH] = mem[rd_ptr + ptr_t'(j)];
            end
        end
    end

    assign wr_if.empty = (count == '0);
    assign rd_no_loc   = rd_no_loc_c;
    assign free_locs   = free_locs_c;

endmodule

// File: tb/tb_frag_buffer.sv
// Directed bench for frag_buffer with a queue scoreboard of expected DWs.
module tb_frag_buffer;
    import frag_buffer_pkg::*;

    logic clk;
    logic rst;
    logic rd_en;
    logic [RD_DATA_WIDTH-1:0]   rd_data;
    logic [NO_LOC_RD_WIDTH-1:0] rd_no_loc;
    logic [CNT_WIDTH-1:0]       free_locs;
    logic                       overflow_err;

    frag_buffer_if wr_if ();

    frag_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .wr_if        (wr_if.slave),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_no_loc    (rd_no_loc),
        .free_locs    (free_locs),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    loc_t sb_q[$];
    int   m_count  = 0;
    logic m_ovf    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_empty"}, 64'(wr_if.empty), 64'(m_count == 0));
        check({tag, "_free"}, 64'(free_locs), 64'(int'(DEPTH) - m_count));
        check({tag, "_ovf"}, 64'(overflow_err), 64'(m_ovf));
    endtask

    // One clock: optional read check/pop before the edge, model update after it
    task automatic cycle(input logic wen, input int n, input logic [WR_DATA_WIDTH-1:0] d,
                         input logic ren, input string tag);
        int   exp_rd;
        logic acc;
        loc_t exp_slot;
        exp_rd = (m_count >= int'(RD_LOCS)) ? int'(RD_LOCS) : m_count;
        if (ren) begin
            check({tag, "_rd_no_loc"}, 64'(rd_no_loc), 64'(exp_rd));
            for (int j = 0; j < int'(RD_LOCS); j++) begin
                exp_slot = (j < exp_rd) ? sb_q.pop_front() : '0;
                check($sformatf("%s_slot%0d", tag, j), 64'(rd_data[j*LOC_WIDTH +: LOC_WIDTH]),
                      64'(exp_slot));
            end
        end
        wr_if.wr_en     = wen;
        wr_if.data_in   = d;
        wr_if.no_loc_wr = NO_LOC_WR_WIDTH'(n);
        rd_en           = ren;
        acc = wen && n != 0 && n <= int'(WR_LOCS) && n <= int'(DEPTH) - m_count;
        @(posedge clk);
        #1;
        wr_if.wr_en     = 1'b0;
        wr_if.data_in   = '0;
        wr_if.no_loc_wr = '0;
        rd_en           = 1'b0;
        if (acc) begin
            for (int k = 0; k < n; k++) sb_q.push_back(d[k*LOC_WIDTH +: LOC_WIDTH]);
        end else if (wen && n != 0) begin
            m_ovf = 1'b1;
        end
        m_count = m_count + (acc ? n : 0) - (ren ? exp_rd : 0);
        check_status(tag);
    endtask

    function automatic logic [WR_DATA_WIDTH-1:0] mk_data(input int n, input int base);
        logic [WR_DATA_WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < n && k < int'(WR_LOCS); k++) d[k*LOC_WIDTH +: LOC_WIDTH] = loc_t'(base + k);
        return d;
    endfunction

    task automatic wr(input int n, input int base, input string tag);
        cycle(1'b1, n, mk_data(n, base), 1'b0, tag);
    endtask

    task automatic rd(input string tag);
        cycle(1'b0, 0, '0, 1'b1, tag);
    endtask

    // Reset with a live write on the bus; it must be ignored
    task automatic do_reset(input string tag);
        rst             = 1'b1;
        wr_if.wr_en     = 1'b1;
        wr_if.no_loc_wr = NO_LOC_WR_WIDTH'(WR_LOCS);
        wr_if.data_in   = mk_data(int'(WR_LOCS), 32'hdead0000);
        rd_en           = 1'b1;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        wr_if.wr_en     = 1'b0;
        wr_if.no_loc_wr = '0;
        wr_if.data_in   = '0;
        rd_en           = 1'b0;
        sb_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        check_status(tag);
        check({tag, "_rd_no_loc"}, 64'(rd_no_loc), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data == '0), 64'd1);
    endtask

    initial begin
        int base;
        rst             = 1'b1;
        rd_en           = 1'b0;
        wr_if.wr_en     = 1'b0;
        wr_if.data_in   = '0;
        wr_if.no_loc_wr = '0;
        @(posedge clk);
        do_reset("reset");

        // Zero-length write is a no-op
        wr(0, 0, "zero_wr");

        // Full-width write drained by two pops
        wr(8, 32'h10, "wr8");
        cycle(1'b0, 0, '0, 1'b0, "idle");
        rd("rd8_a");
        rd("rd8_b");

        // Short write leaves upper slots zero
        wr(3, 32'hA, "wr3");
        rd("rd3");

        // Wrap-around from index 30
        do_reset("reset_wrap");
        wr(8, 32'h100, "fill_a");
        wr(8, 32'h108, "fill_b");
        wr(8, 32'h110, "fill_c");
        wr(6, 32'h118, "fill_d");
        for (int r = 0; r < 7; r++) rd($sformatf("drain%0d", r));
        wr(8, 32'h80, "wrap_wr");
        for (int r = 0; r < 3; r++) rd($sformatf("wrap_rd%0d", r));

        // Overflow: too little free space
        do_reset("reset_ovf");
        wr(8, 32'h200, "ovf_fill_a");
        wr(8, 32'h208, "ovf_fill_b");
        wr(8, 32'h210, "ovf_fill_c");
        wr(3, 32'h218, "ovf_fill_d");
        wr(8, 32'hbad0, "ovf_drop8");
        rd("ovf_sticky_rd");
        cycle(1'b0, 0, '0, 1'b0, "ovf_sticky_idle");

        // Overflow: count above WR_LOCS, and no credit for same-cycle reads
        do_reset("reset_ovf2");
        wr(8, 32'h300, "ovf2_fill_a");
        wr(8, 32'h308, "ovf2_fill_b");
        wr(8, 32'h310, "ovf2_fill_c");
        wr(4, 32'h318, "ovf2_fill_d");
        wr(9, 32'hbad1, "ovf2_drop9");
        cycle(1'b1, 5, mk_data(5, 32'hbad2), 1'b1, "ovf2_no_credit");
        for (int r = 0; r < 6; r++) rd($sformatf("ovf2_drain%0d", r));

        // Simultaneous read and write
        do_reset("reset_sim");
        base = int'($urandom_range(32'h0fff_0000, 0));
        wr(4, base, "sim_pre");
        cycle(1'b1, 6, mk_data(6, base + 32'h1000), 1'b1, "sim_rw");
        rd("sim_rd_a");
        rd("sim_rd_b");

        // Reset mid-stream
        wr(8, 32'h400, "mid_wr");
        do_reset("reset_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
